bridge_fanout: RTL and testbench
================================

Name: bridge_fanout

Overview:
- Registered N-leaf successor to the flat bridge connection.
- Decodes each host bridge access against per-leaf address windows and strobes `wr`/`rd` only to the matching leaf; the point-to-point form broadcasts strobes.
- Handles leaf read latency, and returns a default value for unmapped reads.
- Sits between the APF bridge endpoint in core_top and the core's register blocks and memories.

Parameters:
- NUM_LEAVES, 4, number of leaf ports (1..16).
- LEAF_BASE, {NUM_LEAVES{32'h0}}, packed array of 32-bit window base addresses; leaf i owns addr where (addr & LEAF_MASK[i]) == LEAF_BASE[i].
- LEAF_MASK, {NUM_LEAVES{32'hF000_0000}}, packed array of 32-bit window masks.
- RD_LATENCY, 1, leaf read latency in cycles from leaf_rd to valid leaf_rd_data (0..7); common to all leaves.
- DEFAULT_DATA, 32'h0000_0000, rd_data value returned for unmapped reads.

Ports:
- clk  in  1  bridge clock.
- reset_n  in  1  asynchronous active-low reset.
- addr  in  32  host bridge address (pocket::bridge_addr_t).
- wr_data  in  32  host write data (pocket::bridge_data_t).
- wr  in  1  host write strobe, one cycle per access.
- rd  in  1  host read strobe, one cycle per access.
- rd_data  out  32  registered read result.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- busy  out  1  read in flight.
- leaf_addr  out  32  registered address, shared by all leaves.
- leaf_wr_data  out  32  registered write data, shared.
- leaf_wr  out  NUM_LEAVES  one-hot write strobes.
- leaf_rd  out  NUM_LEAVES  one-hot read strobes.
- leaf_rd_data  in  NUM_LEAVES*32  per-leaf read data, leaf i at bits [32*i+:32].
- unmapped_count  out  16  saturating count of unmapped accesses.

Behaviour:
- Reset values: all outputs 0. rd_data resets to 0, not DEFAULT_DATA. FSM resets to IDLE.
- Decode:
  - Combinational on addr.
  - Lowest-index matching leaf wins when windows overlap.
  - No match means unmapped.
- Request stage:
  - wr or rd sampled at edge E0.
  - leaf_addr and leaf_wr_data are loaded at E0 for every accepted access.
  - The matching leaf_wr[i] or leaf_rd[i] is high for exactly the cycle after E0; at most one leaf strobe bit is ever high.
- Simultaneous wr and rd: wr is accepted; rd is dropped with no read started and no count.
- Writes:
  - Fire-and-forget; they never affect the FSM.
  - Writes during WAIT are forwarded normally.
  - Unmapped writes generate no strobe and increment unmapped_count.
- Read FSM:
  - IDLE -> on mapped rd: latch leaf index, cnt = RD_LATENCY, go to WAIT.
  - IDLE -> on unmapped rd: at the next edge, rd_data = DEFAULT_DATA, rd_valid = 1, increment unmapped_count; stay in IDLE.
  - WAIT: cnt decrements each edge. At the edge where cnt == 0, capture leaf_rd_data[idx] into rd_data, pulse rd_valid, return to IDLE.
  - Capture edge is E0+1+RD_LATENCY; rd_valid is high in the following cycle.
  - RD_LATENCY = 0 means the leaf's data is combinational in the leaf_rd cycle.
- Read latency:
  - busy = 1 whenever state == WAIT.
  - Mapped read: rd_valid appears RD_LATENCY+2 cycles after the cycle in which rd is high.
  - Unmapped read: 1 cycle.
- New rd while in WAIT:
  - The old read is abandoned with no rd_valid.
  - The new read restarts decode and counter (a mapped rd re-enters WAIT; an unmapped rd returns DEFAULT_DATA next edge).
  - The host is assumed not to do this, but the behaviour is defined.
- rd_data holds its value until the next rd_valid.
- unmapped_count saturates at 16'hFFFF and never wraps.
- Reset asserted mid-read: the FSM returns to IDLE immediately (asynchronous); no rd_valid is issued after release.

Decomposition:
- Add to package pocket:
  - typedef bridge_window_t, struct {bridge_addr_t base; bridge_addr_t mask;}.
  - constant BRIDGE_RD_LATENCY_MAX = 7.
- Sub-module bridge_addr_decode:
  - Combinational priority matcher.
  - Inputs: addr and the window arrays.
  - Outputs: hit, one-hot sel, and a $clog2 index.
  - Reused by later multi-master arbitration blocks.

Test Plan:
- Reset, NUM_LEAVES=4, leaf i base 32'h{i}000_0000, mask F000_0000 -> all outputs 0, busy 0, unmapped_count 0.
- wr addr=32'h2000_0010, wr_data=32'hA5A5_0001 -> leaf_wr = 4'b0100 for one cycle with leaf_addr = 32'h2000_0010 and leaf_wr_data = 32'hA5A5_0001; no other strobes.
- RD_LATENCY=2, rd addr=32'h1000_0004, leaf1 returns 32'h1234_5678 -> leaf_rd = 4'b0010 one cycle, busy 3 cycles, rd_valid in cycle 4 after rd, rd_data = 32'h1234_5678.
- rd addr=32'h8000_0000 (unmapped), DEFAULT_DATA = 32'hDEAD_BEEF -> no leaf_rd, next cycle rd_valid with rd_data = 32'hDEAD_BEEF, unmapped_count = 1; preload count to FFFE and issue 3 unmapped accesses -> count holds FFFF.
- Overlap: leaf0 mask 0, leaf2 matching -> leaf0 wins; rd and wr same cycle -> only leaf_wr fires, no rd_valid.
- rd to leaf3, then rd to leaf1 during WAIT, then reset_n low mid-WAIT -> only the leaf1 result gets rd_valid; after the reset release, busy 0 and no rd_valid.

Source files
------------

// File: rtl/pocket.sv
// pocket: shared bridge types, limits and helpers for the core's bridge fabric.
package pocket;
    typedef logic [31:0] bridge_addr_t;
    typedef logic [31:0] bridge_data_t;
    typedef struct packed {
        bridge_addr_t base;
        bridge_addr_t mask;
    } bridge_window_t;
    localparam int BRIDGE_RD_LATENCY_MAX = 7;
    typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bridge_addr_decode.sv
// bridge_addr_decode: combinational priority window matcher, lowest index wins on overlap.
module bridge_addr_decode
    import pocket::*;
#(
    parameter int NUM_LEAVES = 4
) (
    input  logic [31:0]                     addr,
    input  bridge_window_t [NUM_LEAVES-1:0] win,
    output logic                            hit,
    output logic [NUM_LEAVES-1:0]           sel,
    output logic [idx_w(NUM_LEAVES)-1:0]    idx
);
    localparam int IDX_W = idx_w(NUM_LEAVES);
    // Scan high to low so the lowest matching leaf is the last one written.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
            if ((addr & win[i].mask) == win[i].base) begin
                hit = 1'b1;
                sel = '0;
                sel[i] = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/bridge_fanout.sv
// bridge_fanout: registered host bridge fan-out to N leaves with window decode,
// read latency tracking and default data for unmapped reads.
module bridge_fanout
    import pocket::*;
#(
    parameter int                         NUM_LEAVES   = 4,
    parameter logic [NUM_LEAVES*32-1:0]   LEAF_BASE    = {NUM_LEAVES{32'h0}},
    parameter logic [NUM_LEAVES*32-1:0]   LEAF_MASK    = {NUM_LEAVES{32'hF000_0000}},
    parameter int                         RD_LATENCY   = 1,
    parameter logic [31:0]                DEFAULT_DATA = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              addr,
    input  logic [31:0]              wr_data,
    input  logic                     wr,
    input  logic                     rd,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic [31:0]              leaf_addr,
    output logic [31:0]              leaf_wr_data,
    output logic [NUM_LEAVES-1:0]    leaf_wr,
    output logic [NUM_LEAVES-1:0]    leaf_rd,
    input  logic [NUM_LEAVES*32-1:0] leaf_rd_data,
    output logic [15:0]              unmapped_count
);
    localparam int IDX_W = idx_w(NUM_LEAVES);
    localparam int CNT_W = $clog2(BRIDGE_RD_LATENCY_MAX + 1);

    bridge_window_t [NUM_LEAVES-1:0] win;
    logic [NUM_LEAVES-1:0][31:0]     leaf_words;
    logic                            hit;
    logic [NUM_LEAVES-1:0]           sel;
    logic [IDX_W-1:0]                idx;
    logic [IDX_W-1:0]                idx_q;
    logic [CNT_W-1:0]                cnt;
    rd_state_t                       state;
    logic                            rd_go;

    for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_win
        assign win[i] = {LEAF_BASE[32*i+:32], LEAF_MASK[32*i+:32]};
    end

    assign leaf_words = leaf_rd_data;
    // A write in the same cycle takes the slot; the read is dropped entirely.
    assign rd_go = rd && !wr;
    assign busy = state == RD_WAIT;

    bridge_addr_decode #(.NUM_LEAVES(NUM_LEAVES)) u_decode (
        .addr (addr),
        .win  (win),
        .hit  (hit),
        .sel  (sel),
        .idx  (idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RD_IDLE;
            idx_q          <= '0;
            cnt            <= '0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            leaf_addr      <= '0;
            leaf_wr_data   <= '0;
            leaf_wr        <= '0;
            leaf_rd        <= '0;
            unmapped_count <= '0;
        end else begin
            rd_valid <= 1'b0;
            leaf_wr  <= wr ? sel : '0;
            leaf_rd  <= rd_go ? sel : '0;
            if (wr || rd) begin
                leaf_addr    <= addr;
                leaf_wr_data <= wr_data;
            end
            if ((wr || rd) && !hit && unmapped_count != 16'hFFFF)
                unmapped_count <= unmapped_count + 16'd1;
            // A new read always restarts, abandoning any read still waiting.
            if (rd_go) begin
                if (hit) begin
                    state <= RD_WAIT;
                    idx_q <= idx;
                    cnt   <= CNT_W'(RD_LATENCY);
                end else begin
                    state    <= RD_IDLE;
                    rd_data  <= DEFAULT_DATA;
                    rd_valid <= 1'b1;
                end
            end else if (state == RD_WAIT) begin
                if (cnt == '0) begin
                    rd_data  <= leaf_words[idx_q];
                    rd_valid <= 1'b1;
                    state    <= RD_IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bridge_fanout.sv
// tb_bridge_fanout: randomized and directed checks of two bridge_fanout configurations
// against a due-cycle reference model of the bridge protocol.
module tb_bridge_fanout;
    localparam logic [127:0] BASE  = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [127:0] MASK0 = {4{32'hF000_0000}};
    localparam logic [127:0] MASK1 = {{3{32'hF000_0000}}, 32'h0000_0000};
    localparam int           LAT [2] = '{2, 0};
    localparam logic [31:0]  DEF [2] = '{32'hDEAD_BEEF, 32'h0BAD_F00D};

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wr_data = '0;
    logic         wr = 1'b0;
    logic         rd = 1'b0;
    logic [31:0]  leaf_mem [4];
    logic [127:0] leaf_rd_data;

    logic [31:0] rd_data_o [2];
    logic        rd_valid_o [2];
    logic        busy_o [2];
    logic [31:0] leaf_addr_o [2];
    logic [31:0] leaf_wr_data_o [2];
    logic [3:0]  leaf_wr_o [2];
    logic [3:0]  leaf_rd_o [2];
    logic [15:0] cnt_o [2];

    int          m_cnt [2];
    bit          m_pend [2];
    int          m_leaf [2];
    int          m_due [2];
    logic [31:0] ex_rd [2];
    logic [31:0] ex_addr [2];
    logic [31:0] ex_wd [2];
    logic [3:0]  ex_lw [2];
    logic [3:0]  ex_lr [2];
    logic        ex_v [2];
    logic        ex_busy [2];

    int tcyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        leaf_rd_data = '0;
        for (int i = 0; i < 4; i++) leaf_rd_data[32*i+:32] = leaf_mem[i];
    end

    bridge_fanout #(
        .NUM_LEAVES(4), .LEAF_BASE(BASE), .LEAF_MASK(MASK0),
        .RD_LATENCY(2), .DEFAULT_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_data(wr_data), .wr(wr), .rd(rd),
        .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]), .busy(busy_o[0]),
        .leaf_addr(leaf_addr_o[0]), .leaf_wr_data(leaf_wr_data_o[0]),
        .leaf_wr(leaf_wr_o[0]), .leaf_rd(leaf_rd_o[0]), .leaf_rd_data(leaf_rd_data),
        .unmapped_count(cnt_o[0])
    );

    bridge_fanout #(
        .NUM_LEAVES(4), .LEAF_BASE(BASE), .LEAF_MASK(MASK1),
        .RD_LATENCY(0), .DEFAULT_DATA(32'h0BAD_F00D)
    ) dut_ov (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_data(wr_data), .wr(wr), .rd(rd),
        .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]), .busy(busy_o[1]),
        .leaf_addr(leaf_addr_o[1]), .leaf_wr_data(leaf_wr_data_o[1]),
        .leaf_wr(leaf_wr_o[1]), .leaf_rd(leaf_rd_o[1]), .leaf_rd_data(leaf_rd_data),
        .unmapped_count(cnt_o[1])
    );

    function automatic int ref_leaf(input int j, input logic [31:0] a);
        logic [127:0] mk;
        mk = (j == 0) ? MASK0 : MASK1;
        for (int i = 0; i < 4; i++)
            if ((a & mk[32*i+:32]) == BASE[32*i+:32]) return i;
        return -1;
    endfunction

    // Drive one host cycle and advance the reference model to the cycle that follows it.
    task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        int h;
        wr = w;
        rd = r;
        addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        tcyc++;
        for (int j = 0; j < 2; j++) begin
            h = ref_leaf(j, a);
            ex_lw[j] = (w && h >= 0) ? 4'(1 << h) : 4'h0;
            ex_lr[j] = (r && !w && h >= 0) ? 4'(1 << h) : 4'h0;
            ex_v[j] = 1'b0;
            if (w || r) begin
                ex_addr[j] = a;
                ex_wd[j] = d;
                if (h < 0 && m_cnt[j] < 65535) m_cnt[j]++;
            end
            if (r && !w) begin
                if (h >= 0) begin
                    m_pend[j] = 1'b1;
                    m_leaf[j] = h;
                    m_due[j] = tcyc + 1 + LAT[j];
                end else begin
                    m_pend[j] = 1'b0;
                    ex_v[j] = 1'b1;
                    ex_rd[j] = DEF[j];
                end
            end
            if (m_pend[j] && m_due[j] == tcyc) begin
                ex_v[j] = 1'b1;
                ex_rd[j] = leaf_mem[m_leaf[j]];
                m_pend[j] = 1'b0;
            end
            ex_busy[j] = m_pend[j];
        end
    endtask

    task automatic pulse_reset;
        #3 reset_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            m_cnt[j] = 0;
            m_pend[j] = 1'b0;
            ex_rd[j] = '0;
            ex_addr[j] = '0;
            ex_wd[j] = '0;
            ex_lw[j] = '0;
            ex_lr[j] = '0;
            ex_v[j] = 1'b0;
            ex_busy[j] = 1'b0;
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [121:0] got;
        @(posedge clk);
        pulse_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 2; j++) begin
                got = {leaf_wr_o[j], leaf_rd_o[j], leaf_addr_o[j], leaf_wr_data_o[j], cnt_o[j],
                       rd_valid_o[j], rd_data_o[j], busy_o[j]};
                vectors++;
                if (got !== '0) begin
                    miscompares++;
                    $display("FAIL reset dut%0d pass%0d: got %h want 0", j, k, got);
                end
            end
            step(1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic test_write;
        step(1'b1, 1'b0, 32'h2000_0010, 32'hA5A5_0001);
        vectors++;
        if ({leaf_wr_o[0], leaf_rd_o[0], leaf_addr_o[0], leaf_wr_data_o[0]} !==
            {4'b0100, 4'b0000, 32'h2000_0010, 32'hA5A5_0001}) begin
            miscompares++;
            $display("FAIL write: wr=%b rd=%b addr=%h data=%h want 0100 0000 20000010 a5a50001",
                     leaf_wr_o[0], leaf_rd_o[0], leaf_addr_o[0], leaf_wr_data_o[0]);
        end
        step(1'b0, 1'b0, 32'h0, 32'h0);
        vectors++;
        if (leaf_wr_o[0] !== 4'b0000 || leaf_addr_o[0] !== 32'h2000_0010) begin
            miscompares++;
            $display("FAIL write_after: wr=%b addr=%h want 0000 20000010", leaf_wr_o[0], leaf_addr_o[0]);
        end
    endtask

    task automatic test_read_latency;
        leaf_mem[1] = 32'h1234_5678;
        step(1'b0, 1'b1, 32'h1000_0004, 32'h0);
        vectors++;
        if (leaf_rd_o[0] !== 4'b0010) begin
            miscompares++;
            $display("FAIL read_strobe: leaf_rd=%b want 0010", leaf_rd_o[0]);
        end
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (busy_o[0] !== (i < 4) || rd_valid_o[0] !== (i == 4)) begin
                miscompares++;
                $display("FAIL read_timing cycle%0d: busy=%b valid=%b want %b %b",
                         i, busy_o[0], rd_valid_o[0], i < 4, i == 4);
            end
            if (i < 4) step(1'b0, 1'b0, 32'h0, 32'h0);
        end
        vectors++;
        if (rd_data_o[0] !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL read_data: got %h want 12345678", rd_data_o[0]);
        end
    endtask

    task automatic test_unmapped;
        step(1'b0, 1'b1, 32'h8000_0000, 32'h0);
        vectors++;
        if ({leaf_rd_o[0], rd_valid_o[0], rd_data_o[0], cnt_o[0]} !== {4'b0000, 1'b1, 32'hDEAD_BEEF, 16'd1}) begin
            miscompares++;
            $display("FAIL unmapped_read: rd=%b valid=%b data=%h cnt=%h want 0000 1 deadbeef 0001",
                     leaf_rd_o[0], rd_valid_o[0], rd_data_o[0], cnt_o[0]);
        end
        step(1'b0, 1'b0, 32'h0, 32'h0);
        vectors++;
        if (rd_valid_o[0] !== 1'b0 || rd_data_o[0] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL unmapped_hold: valid=%b data=%h want 0 deadbeef", rd_valid_o[0], rd_data_o[0]);
        end
    endtask

    task automatic test_overlap;
        step(1'b1, 1'b0, 32'h2000_0000, 32'h0000_0022);
        vectors++;
        if (leaf_wr_o[1] !== 4'b0001 || leaf_wr_o[0] !== 4'b0100) begin
            miscompares++;
            $display("FAIL overlap: ov=%b plain=%b want 0001 0100", leaf_wr_o[1], leaf_wr_o[0]);
        end
        step(1'b1, 1'b1, 32'h1000_0000, 32'h0000_0033);
        vectors++;
        if (leaf_wr_o[0] !== 4'b0010 || leaf_rd_o[0] !== 4'b0000 || leaf_rd_o[1] !== 4'b0000) begin
            miscompares++;
            $display("FAIL wr_rd_same: wr=%b rd=%b rd_ov=%b want 0010 0000 0000",
                     leaf_wr_o[0], leaf_rd_o[0], leaf_rd_o[1]);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rd_valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || rd_valid_o[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL wr_rd_noread cycle%0d: valid=%b busy=%b valid_ov=%b want 0 0 0",
                         i, rd_valid_o[0], busy_o[0], rd_valid_o[1]);
            end
            step(1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic test_abandon;
        leaf_mem[3] = 32'h3333_AAAA;
        leaf_mem[1] = 32'h1111_BBBB;
        step(1'b0, 1'b1, 32'h3000_0000, 32'h0);
        step(1'b0, 1'b1, 32'h1000_0000, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0);
            vectors++;
            if (rd_valid_o[0] !== (i == 3)) begin
                miscompares++;
                $display("FAIL abandon_valid cycle%0d: valid=%b want %b", i, rd_valid_o[0], i == 3);
            end
            if (i == 3) begin
                vectors++;
                if (rd_data_o[0] !== 32'h1111_BBBB) begin
                    miscompares++;
                    $display("FAIL abandon_data: got %h want 1111bbbb", rd_data_o[0]);
                end
            end
        end
        step(1'b0, 1'b1, 32'h2000_0000, 32'h0);
        vectors++;
        if (busy_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_busy: got %b want 1", busy_o[0]);
        end
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (busy_o[0] !== 1'b0 || rd_valid_o[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset cycle%0d: busy=%b valid=%b want 0 0", i, busy_o[0], rd_valid_o[0]);
            end
            step(1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic test_random;
        logic [121:0] got;
        logic [121:0] want;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) leaf_mem[i] = $urandom;
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 {4'($urandom_range(0, 7)), 28'($urandom)}, $urandom);
            for (int j = 0; j < 2; j++) begin
                got = {leaf_wr_o[j], leaf_rd_o[j], leaf_addr_o[j], leaf_wr_data_o[j], cnt_o[j],
                       rd_valid_o[j], rd_data_o[j], busy_o[j]};
                want = {ex_lw[j], ex_lr[j], ex_addr[j], ex_wd[j], 16'(m_cnt[j]),
                        ex_v[j], ex_rd[j], ex_busy[j]};
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL random dut%0d step%0d: got %h want %h", j, n, got, want);
                end
            end
        end
    endtask

    task automatic test_saturate;
        while (m_cnt[0] < 65534) begin
            step(1'b1, 1'b0, 32'h9000_0000 | ($urandom & 32'h0FFF_FFFF), $urandom);
            vectors++;
            if (cnt_o[0] !== 16'(m_cnt[0])) begin
                miscompares++;
                $display("FAIL count_ramp: got %h want %h", cnt_o[0], 16'(m_cnt[0]));
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(i != 1, i == 1, 32'hF000_0000, 32'h0);
            vectors++;
            if (cnt_o[0] !== ((i == 0) ? 16'hFFFF : 16'hFFFF) || cnt_o[0] !== 16'(m_cnt[0])) begin
                miscompares++;
                $display("FAIL count_saturate access%0d: got %h want ffff", i, cnt_o[0]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) leaf_mem[i] = '0;
        test_reset();
        test_write();
        test_read_latency();
        test_unmapped();
        test_overlap();
        test_abandon();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
